// File: rtl/mac_pkg.sv
// Shared types and constants for the multiplier/accumulator datapath.
package mac_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_t;

  localparam int unsigned PROD_W      = 16;
  localparam int unsigned DEF_DOT_LEN = 8;
  localparam int unsigned DEF_ACC_W   = 19;

  // Smallest accumulator width that can never saturate for a given vector length.
  function automatic int unsigned min_acc_w(input int unsigned dot_len);
    return PROD_W + $clog2(dot_len);
  endfunction

endpackage

// File: rtl/sat_add_u.sv
// Unsigned ACC_W-bit + 16-bit adder that clamps to all-ones instead of wrapping.
module sat_add_u
  import mac_pkg::*;
#(
  parameter int unsigned ACC_W = DEF_ACC_W
) (
  input  logic [ACC_W-1:0]  a,
  input  logic [PROD_W-1:0] b,
  output logic [ACC_W-1:0]  sum_c,
  output logic              ovf_c
);

  logic [ACC_W:0] full;

  always_comb begin
    full  = {1'b0, a} + (ACC_W+1)'(b);
    ovf_c = full[ACC_W];
    sum_c = full[ACC_W] ? '1 : full[ACC_W-1:0];
  end

endmodule

// File: rtl/product_accumulator.sv
// Sums DOT_LEN consecutive products into a saturating accumulator and
// presents each vector's result on a valid/ready port.
module product_accumulator
  import mac_pkg::*;
#(
  parameter int unsigned DOT_LEN = DEF_DOT_LEN,
  parameter int unsigned ACC_W   = DEF_ACC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] prod,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  result,
  output logic              ovf,
  output logic              busy
);

  localparam int unsigned CNT_W = $clog2(DOT_LEN) + 1;

  state_t             state, state_n;
  logic [CNT_W-1:0]   count, count_n;
  logic [ACC_W-1:0]   acc, acc_n;
  logic               sticky, sticky_n;
  logic [ACC_W-1:0]   result_n;
  logic               ovf_n;
  logic               out_valid_n;

  logic [ACC_W-1:0]   add_sum;
  logic               add_ovf;
  logic [ACC_W-1:0]   new_sum;
  logic               new_sticky;
  logic               first_beat;
  logic               last_beat;
  logic               in_xfer;
  logic               out_xfer;

  sat_add_u #(.ACC_W(ACC_W)) u_add (
    .a     (acc),
    .b     (prod),
    .sum_c (add_sum),
    .ovf_c (add_ovf)
  );

  // Ready is combinational from out_ready so a held result can drain and refill in one cycle.
  assign in_ready = (state == ACCUM) || (state == DONE && out_ready);
  assign busy     = (count != '0);

  always_comb begin
    in_xfer     = in_valid && in_ready;
    out_xfer    = out_valid && out_ready;
    first_beat  = (count == '0);
    last_beat   = (count == CNT_W'(DOT_LEN - 1));
    new_sum     = first_beat ? ACC_W'(prod) : add_sum;
    new_sticky  = first_beat ? 1'b0 : (sticky | add_ovf);

    state_n     = state;
    count_n     = count;
    acc_n       = acc;
    sticky_n    = sticky;
    result_n    = result;
    ovf_n       = ovf;
    out_valid_n = out_valid;

    if (clear) begin
      state_n     = ACCUM;
      count_n     = '0;
      acc_n       = '0;
      sticky_n    = 1'b0;
      out_valid_n = 1'b0;
    end else begin
      if (state == DONE && out_xfer) begin
        state_n     = ACCUM;
        out_valid_n = 1'b0;
      end
      // A completing beat overrides the drain above, which covers DOT_LEN == 1 back-to-back.
      if (in_xfer) begin
        if (last_beat) begin
          result_n    = new_sum;
          ovf_n       = new_sticky;
          out_valid_n = 1'b1;
          state_n     = DONE;
          count_n     = '0;
        end else begin
          acc_n    = new_sum;
          sticky_n = new_sticky;
          count_n  = count + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ACCUM;
      count     <= '0;
      acc       <= '0;
      sticky    <= 1'b0;
      result    <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_n;
      count     <= count_n;
      acc       <= acc_n;
      sticky    <= sticky_n;
      result    <= result_n;
      ovf       <= ovf_n;
      out_valid <= out_valid_n;
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Self-checking bench: scoreboard on a DOT_LEN=4/ACC_W=17 instance plus a DOT_LEN=1 instance.
module tb_product_accumulator;

  localparam int A_LEN = 4;
  localparam int A_MAX = (1 << 17) - 1;

  logic clk = 1'b0;
  logic rst;

  logic        a_clear, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_ovf, a_busy;
  logic [15:0] a_prod;
  logic [16:0] a_result;

  logic        b_clear, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_ovf, b_busy;
  logic [15:0] b_prod;
  logic [18:0] b_result;

  int n_checks = 0;
  int n_fail   = 0;

  int exp_res_q[$];
  int exp_ovf_q[$];
  int m_count = 0;
  int m_sum   = 0;
  int m_ovf   = 0;

  always #5 clk = ~clk;

  product_accumulator #(.DOT_LEN(4), .ACC_W(17)) u_dut_a (
    .clk(clk), .rst(rst), .clear(a_clear), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .prod(a_prod), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .result(a_result), .ovf(a_ovf), .busy(a_busy)
  );

  product_accumulator #(.DOT_LEN(1), .ACC_W(19)) u_dut_b (
    .clk(clk), .rst(rst), .clear(b_clear), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .prod(b_prod), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .result(b_result), .ovf(b_ovf), .busy(b_busy)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model of the saturating sum; pushes the expected result when a vector completes.
  task automatic model_beat(input int p);
    if (m_count == 0) begin
      m_sum = p;
      m_ovf = 0;
    end else begin
      m_sum = m_sum + p;
      if (m_sum > A_MAX) begin
        m_sum = A_MAX;
        m_ovf = 1;
      end
    end
    m_count++;
    if (m_count == A_LEN) begin
      exp_res_q.push_back(m_sum);
      exp_ovf_q.push_back(m_ovf);
      m_count = 0;
    end
  endtask

  task automatic send_beat(input int p);
    bit ok;
    ok = 1'b0;
    a_in_valid = 1'b1;
    a_prod     = 16'(p);
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (a_in_ready) ok = 1'b1;
      tick();
    end
    a_in_valid = 1'b0;
    if (ok) model_beat(p);
    else check("accept_timeout", 0, 1);
  endtask

  // Scoreboard: compare every output transfer against the oldest expected result.
  always @(negedge clk) begin
    if (!rst && a_out_valid && a_out_ready) begin
      if (exp_res_q.size() == 0) begin
        check("sb_unexpected_output", 1, 0);
      end else begin
        check("sb_result", int'(a_result), exp_res_q.pop_front());
        check("sb_ovf", int'(a_ovf), exp_ovf_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    a_clear = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b0; a_prod = '0;
    b_clear = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b0; b_prod = '0;
    tick(); tick();
    check("rst_a_out_valid", int'(a_out_valid), 0);
    check("rst_a_result", int'(a_result), 0);
    check("rst_a_busy", int'(a_busy), 0);
    check("rst_a_in_ready", int'(a_in_ready), 1);
    check("rst_b_out_valid", int'(b_out_valid), 0);
    check("rst_b_busy", int'(b_busy), 0);
    rst = 1'b0;
    tick();

    // Basic vector, consecutive beats, latency of one cycle after the last beat
    a_out_ready = 1'b1;
    send_beat(100);
    send_beat(200);
    check("busy_mid", int'(a_busy), 1);
    send_beat(300);
    send_beat(400);
    check("lat_valid", int'(a_out_valid), 1);
    check("lat_result", int'(a_result), 1000);
    check("lat_ovf", int'(a_ovf), 0);
    check("busy_after", int'(a_busy), 0);
    tick();
    check("drain_valid", int'(a_out_valid), 0);

    // Saturation, then sticky overflow cleared on the next vector
    for (int i = 0; i < 4; i++) send_beat(16'hFFFF);
    check("sat_result", int'(a_result), 17'h1FFFF);
    check("sat_ovf", int'(a_ovf), 1);
    for (int i = 0; i < 4; i++) send_beat(1);
    check("unsat_result", int'(a_result), 4);
    check("unsat_ovf", int'(a_ovf), 0);
    tick();

    // Backpressure: result held, nothing consumed while out_ready is low
    a_out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_beat(10);
    a_in_valid = 1'b1;
    a_prod     = 16'd7;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", int'(a_out_valid), 1);
      check("bp_result", int'(a_result), 40);
      check("bp_in_ready", int'(a_in_ready), 0);
      check("bp_busy", int'(a_busy), 0);
      tick();
    end
    a_out_ready = 1'b1;
    send_beat(7);
    check("bp_release_valid", int'(a_out_valid), 0);
    check("bp_release_busy", int'(a_busy), 1);
    for (int i = 0; i < 3; i++) send_beat(7);
    check("bp_next_result", int'(a_result), 28);
    tick();

    // Clear mid-vector drops partial sum and the beat presented with it
    for (int i = 0; i < 3; i++) send_beat(50);
    a_clear = 1'b1; a_in_valid = 1'b1; a_prod = 16'd999;
    tick();
    a_clear = 1'b0; a_in_valid = 1'b0;
    m_count = 0;
    check("clr_busy", int'(a_busy), 0);
    check("clr_valid", int'(a_out_valid), 0);
    for (int i = 0; i < 4; i++) send_beat(1);
    check("clr_result", int'(a_result), 4);
    check("clr_ovf", int'(a_ovf), 0);
    check("clr_busy_done", int'(a_busy), 0);
    tick();

    // Asynchronous reset between edges while a vector is in progress
    for (int i = 0; i < 4; i++) send_beat(16'hFFFF);
    send_beat(500);
    send_beat(500);
    #2;
    rst = 1'b1;
    #1;
    check("arst_result", int'(a_result), 0);
    check("arst_ovf", int'(a_ovf), 0);
    check("arst_busy", int'(a_busy), 0);
    check("arst_valid", int'(a_out_valid), 0);
    m_count = 0;
    tick();
    rst = 1'b0;
    tick();
    send_beat(3); send_beat(4); send_beat(5); send_beat(6);
    check("post_rst_result", int'(a_result), 18);
    tick(); tick();
    check("sb_drained", exp_res_q.size(), 0);

    // DOT_LEN=1 instance: continuous streaming keeps out_valid high
    b_out_ready = 1'b1;
    b_in_valid  = 1'b1;
    for (int p = 5; p <= 7; p++) begin
      b_prod = 16'(p);
      tick();
      check("len1_valid", int'(b_out_valid), 1);
      check("len1_result", int'(b_result), p);
      check("len1_ovf", int'(b_ovf), 0);
    end
    b_in_valid = 1'b0;
    tick();
    check("len1_drain", int'(b_out_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
